pipe_stage_skid: RTL and testbench

- Parametrised successor of the fixed-field inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries one opaque payload bus of DATA_W bits between two pipeline stages using a valid/ready handshake.
- Adds stall back-pressure, synchronous flush and a one-entry skid buffer, so in_ready is driven from a flop, not from out_ready.
- One instance per stage boundary; each stage packs its own fields (rd, func3, opcode, result, PC, ...) into in_data.

---
 rtl/pipe_pkg.sv | 33 +++
 rtl/pipe_data_reg.sv | 24 ++
 rtl/pipe_stage_skid.sv | 117 +++++++++++
 tb/tb_pipe_stage_skid.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the valid/ready pipeline stage registers.
// Stage code uses the MEM/WB field offsets to pack and unpack its payload.
package pipe_pkg;

    // Encoded as {main_valid, skid_valid}; 2'b01 is unreachable.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_FULL  = 2'b11
    } state_t;

    localparam int unsigned MEM_WB_W = 113;

    localparam int unsigned MW_RD_LSB      = 0;
    localparam int unsigned MW_RD_W        = 5;
    localparam int unsigned MW_FUNC3_LSB   = 5;
    localparam int unsigned MW_FUNC3_W     = 3;
    localparam int unsigned MW_OPCODE_LSB  = 8;
    localparam int unsigned MW_OPCODE_W    = 7;
    localparam int unsigned MW_RESULT_LSB  = 15;
    localparam int unsigned MW_RESULT_W    = 32;
    localparam int unsigned MW_REGWR_BIT   = 47;
    localparam int unsigned MW_MEMRD_BIT   = 48;
    localparam int unsigned MW_PC_LSB      = 49;
    localparam int unsigned MW_PC_W        = 32;
    localparam int unsigned MW_MEMDATA_LSB = 81;
    localparam int unsigned MW_MEMDATA_W   = 32;

    function automatic logic [1:0] state_occupancy(input state_t s);
        return {1'b0, s[1]} + {1'b0, s[0]};
    endfunction

endpackage

// File: rtl/pipe_data_reg.sv
// Payload register with load enable; synchronous clear takes priority over load.
module pipe_data_reg #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              i_load,
    input  logic              i_clr,
    input  logic [DATA_W-1:0] i_d,
    output logic [DATA_W-1:0] o_q
);

    logic [DATA_W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake, flush and a one-entry
// skid buffer so that in_ready comes from state rather than from out_ready.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter bit          ZERO_BUBBLE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    state_t r_state;
    state_t w_state_nxt;

    logic              w_main_valid;
    logic              w_skid_valid;
    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_main_load;
    logic              w_main_sel_skid;
    logic              w_skid_load;
    logic              w_main_clr;
    logic              w_skid_clr;
    logic [DATA_W-1:0] w_main_d;
    logic [DATA_W-1:0] w_main_q;
    logic [DATA_W-1:0] w_skid_q;

    assign w_main_valid = r_state[1];
    assign w_skid_valid = r_state[0];

    assign in_ready   = rst & ~w_skid_valid;
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = w_main_valid & out_ready;

    always_comb begin
        w_state_nxt     = r_state;
        w_main_load     = 1'b0;
        w_main_sel_skid = 1'b0;
        w_skid_load     = 1'b0;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        w_state_nxt = ST_ONE;
                        w_main_load = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        w_main_load = 1'b1;
                    end else if (w_in_fire) begin
                        w_state_nxt = ST_FULL;
                        w_skid_load = 1'b1;
                    end else if (w_out_fire) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_out_fire) begin
                        w_state_nxt     = ST_ONE;
                        w_main_load     = 1'b1;
                        w_main_sel_skid = 1'b1;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A register is cleared whenever its valid bit is 0 next cycle, which covers
    // drain, flush and reset in one term when bubbles are zeroed.
    assign w_main_clr = !rst || (ZERO_BUBBLE && !w_state_nxt[1]);
    assign w_skid_clr = !rst || (ZERO_BUBBLE && !w_state_nxt[0]);
    assign w_main_d   = w_main_sel_skid ? w_skid_q : in_data;

    pipe_data_reg #(.DATA_W(DATA_W)) u_main (
        .clk    (clk),
        .i_load (w_main_load),
        .i_clr  (w_main_clr),
        .i_d    (w_main_d),
        .o_q    (w_main_q)
    );

    pipe_data_reg #(.DATA_W(DATA_W)) u_skid (
        .clk    (clk),
        .i_load (w_skid_load),
        .i_clr  (w_skid_clr),
        .i_d    (in_data),
        .o_q    (w_skid_q)
    );

    assign out_valid = w_main_valid;
    assign out_data  = w_main_q;
    assign occupancy = state_occupancy(r_state);

    assert property (@(posedge clk) {w_main_valid, w_skid_valid} != 2'b01);

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: a 113-bit and a 1-bit instance checked every cycle
// against a two-deep queue model, plus directed vectors with literal expectations.
module tb_pipe_stage_skid;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         iv   [2];
    logic         ordy [2];
    logic         fl   [2];
    logic [112:0] idat [2];

    logic         rdy0, rdy1, v0, v1;
    logic [1:0]   occ0, occ1;
    logic [112:0] out_w;
    logic         out_n;

    int n_vec = 0;
    int n_err = 0;

    pipe_stage_skid #(.DATA_W(113), .ZERO_BUBBLE(1'b1)) dut_w (
        .clk       (clk),
        .rst       (rst),
        .flush     (fl[0]),
        .in_valid  (iv[0]),
        .in_ready  (rdy0),
        .in_data   (idat[0]),
        .out_valid (v0),
        .out_ready (ordy[0]),
        .out_data  (out_w),
        .occupancy (occ0)
    );

    pipe_stage_skid #(.DATA_W(1), .ZERO_BUBBLE(1'b1)) dut_n (
        .clk       (clk),
        .rst       (rst),
        .flush     (fl[1]),
        .in_valid  (iv[1]),
        .in_ready  (rdy1),
        .in_data   (idat[1][0]),
        .out_valid (v1),
        .out_ready (ordy[1]),
        .out_data  (out_n),
        .occupancy (occ1)
    );

    // Model: the stage is a FIFO of depth 2; ready means "fewer than two held".
    logic [112:0] q0[$];
    logic [112:0] q1[$];

    always @(posedge clk) begin : model0
        bit inf, outf;
        inf  = iv[0] && rst && (q0.size() < 2);
        outf = (q0.size() > 0) && ordy[0];
        if (!rst || fl[0]) begin
            q0.delete();
        end else begin
            if (outf) void'(q0.pop_front());
            if (inf) q0.push_back(idat[0]);
        end
    end

    always @(posedge clk) begin : model1
        bit inf, outf;
        inf  = iv[1] && rst && (q1.size() < 2);
        outf = (q1.size() > 0) && ordy[1];
        if (!rst || fl[1]) begin
            q1.delete();
        end else begin
            if (outf) void'(q1.pop_front());
            if (inf) q1.push_back({112'b0, idat[1][0]});
        end
    end

    task automatic chk(input string nm, input int k, input logic [112:0] act, input logic [112:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d: got %h want %h at %0t", nm, k, act, exp, $time);
        end
    endtask

    logic         prev_v [2];
    logic [112:0] prev_d [2];
    initial begin
        prev_v[0] = 1'b0;
        prev_v[1] = 1'b0;
    end

    always @(posedge clk) begin : cmp
        #1;
        for (int k = 0; k < 2; k++) begin
            int           sz;
            logic [112:0] front, ad;
            logic         av, ar;
            logic [1:0]   ao;
            sz    = (k == 0) ? q0.size() : q1.size();
            front = '0;
            if (sz > 0) front = (k == 0) ? q0[0] : q1[0];
            av = (k == 0) ? v0 : v1;
            ar = (k == 0) ? rdy0 : rdy1;
            ao = (k == 0) ? occ0 : occ1;
            ad = (k == 0) ? out_w : {112'b0, out_n};
            chk("out_valid", k, av, sz > 0);
            chk("occupancy", k, ao, sz[1:0]);
            chk("in_ready", k, ar, rst && (sz < 2));
            chk("out_data", k, ad, front);
            chk("legal_state", k, (ao == 2'd1) && !av, 1'b0);
            if (prev_v[k] && !ordy[k] && rst && !fl[k])
                chk("stall_stable", k, ad, prev_d[k]);
            prev_v[k] = av;
            prev_d[k] = ad;
        end
    end

    task automatic tick;
        @(posedge clk);
        #3;
    endtask

    task automatic expect0(input string nm, input logic v, input logic [112:0] d,
                           input logic [1:0] occ, input logic r);
        chk({nm, ".valid"}, 0, v0, v);
        chk({nm, ".data"}, 0, out_w, d);
        chk({nm, ".occ"}, 0, occ0, occ);
        chk({nm, ".ready"}, 0, rdy0, r);
    endtask

    initial begin
        logic [127:0] r128;
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            iv[k] = 1'b0; ordy[k] = 1'b1; fl[k] = 1'b0; idat[k] = '0;
        end
        tick; tick;
        expect0("reset_hold", 1'b0, 113'h0, 2'd0, 1'b0);
        rst = 1'b1;
        tick;
        expect0("reset_exit", 1'b0, 113'h0, 2'd0, 1'b1);

        ordy[0] = 1'b0; iv[0] = 1'b1; idat[0] = 113'hA;
        tick; expect0("mid_a", 1'b1, 113'hA, 2'd1, 1'b1);
        idat[0] = 113'hB;
        tick; expect0("mid_b", 1'b1, 113'hA, 2'd2, 1'b0);
        iv[0] = 1'b0; rst = 1'b0;
        tick; expect0("mid_rst", 1'b0, 113'h0, 2'd0, 1'b0);
        rst = 1'b1;
        tick; expect0("mid_after", 1'b0, 113'h0, 2'd0, 1'b1);

        ordy[0] = 1'b1; iv[0] = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            idat[0] = 113'(i);
            tick; expect0("stream", 1'b1, 113'(i), 2'd1, 1'b1);
        end
        iv[0] = 1'b0;
        tick; expect0("stream_end", 1'b0, 113'h0, 2'd0, 1'b1);

        ordy[0] = 1'b0; iv[0] = 1'b1; idat[0] = 113'h11;
        tick; expect0("stall_11", 1'b1, 113'h11, 2'd1, 1'b1);
        idat[0] = 113'h22;
        tick; expect0("stall_22", 1'b1, 113'h11, 2'd2, 1'b0);
        idat[0] = 113'h33;
        tick; expect0("stall_33", 1'b1, 113'h11, 2'd2, 1'b0);
        iv[0] = 1'b0; ordy[0] = 1'b1;
        tick; expect0("drain_22", 1'b1, 113'h22, 2'd1, 1'b1);
        tick; expect0("drain_empty", 1'b0, 113'h0, 2'd0, 1'b1);
        iv[0] = 1'b1; idat[0] = 113'h33;
        tick; expect0("reoffer_33", 1'b1, 113'h33, 2'd1, 1'b1);
        iv[0] = 1'b0;
        tick; expect0("reoffer_end", 1'b0, 113'h0, 2'd0, 1'b1);

        ordy[0] = 1'b0; iv[0] = 1'b1; idat[0] = 113'hA1;
        tick; expect0("fl_a1", 1'b1, 113'hA1, 2'd1, 1'b1);
        idat[0] = 113'hA2;
        tick; expect0("fl_full", 1'b1, 113'hA1, 2'd2, 1'b0);
        fl[0] = 1'b1; idat[0] = 113'h44;
        tick; expect0("flush_full", 1'b0, 113'h0, 2'd0, 1'b1);
        fl[0] = 1'b0; iv[0] = 1'b0;
        tick; expect0("flush_after", 1'b0, 113'h0, 2'd0, 1'b1);
        iv[0] = 1'b1; idat[0] = 113'h77;
        tick; expect0("fl1_77", 1'b1, 113'h77, 2'd1, 1'b1);
        fl[0] = 1'b1; idat[0] = 113'h44;
        tick; expect0("flush_one", 1'b0, 113'h0, 2'd0, 1'b1);
        fl[0] = 1'b0; iv[0] = 1'b0;
        tick; expect0("flush_one_after", 1'b0, 113'h0, 2'd0, 1'b1);

        iv[0] = 1'b1; idat[0] = 113'h55;
        tick; expect0("simul_55", 1'b1, 113'h55, 2'd1, 1'b1);
        ordy[0] = 1'b1; idat[0] = 113'h66;
        tick; expect0("simul_66", 1'b1, 113'h66, 2'd1, 1'b1);
        iv[0] = 1'b0;
        tick; expect0("simul_end", 1'b0, 113'h0, 2'd0, 1'b1);

        for (int c = 0; c < 10000; c++) begin
            rst = ($urandom_range(0, 1999) != 0);
            for (int k = 0; k < 2; k++) begin
                iv[k]   = ($urandom_range(0, 3) != 0);
                ordy[k] = (((c / 700) % 2) == 0) ? ($urandom_range(0, 3) != 0)
                                                  : ($urandom_range(0, 3) == 0);
                fl[k]   = ($urandom_range(0, 99) == 0);
            end
            r128    = {$urandom, $urandom, $urandom, $urandom};
            idat[0] = r128[112:0];
            idat[1] = {112'b0, r128[127]};
            tick;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
